// File: rtl/evr_output_driver.sv
`default_nettype none
// ============================================================================
// evr_output_driver : event-receiver output generator. On a trigger it plays
// a delayed pulse or a stored pattern as SERDES_WIDTH-bit words, one per clock.
// Revision: 1.0
// ============================================================================
module evr_output_driver #(
  parameter int SERDES_WIDTH          = 4,
  parameter int COARSE_DELAY_WIDTH    = 22,
  parameter int COARSE_WIDTH_WIDTH    = 22,
  parameter int PATTERN_ADDRESS_WIDTH = 12
) (
  input  logic                    evrClk,
  input  logic                    evrReset_n,
  input  logic                    csrStrobe,
  input  logic [31:0]             GPIO_OUT,
  input  logic                    triggerStrobe,
  output logic [SERDES_WIDTH-1:0] serdesPattern
);

  localparam int PATTERN_DEPTH = 1 << PATTERN_ADDRESS_WIDTH;

  localparam logic [1:0] OP_SET_MODE    = 2'd0;
  localparam logic [1:0] OP_SET_DELAY   = 2'd1;
  localparam logic [1:0] OP_SET_WIDTH   = 2'd2;
  localparam logic [1:0] OP_SET_PATTERN = 2'd3;

  localparam logic [1:0] MODE_DISABLED = 2'd0;
  localparam logic [1:0] MODE_PULSE    = 2'd1;
  localparam logic [1:0] MODE_LOOP     = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [COARSE_WIDTH_WIDTH-1:0] WIDTH_ONE = {{(COARSE_WIDTH_WIDTH-1){1'b0}}, 1'b1};

  // CSR-visible registers
  logic [1:0]                    mode_q, mode_d;
  logic [COARSE_DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [SERDES_WIDTH-1:0]       first_q, first_d;
  logic [COARSE_WIDTH_WIDTH-1:0] width_q, width_d;
  logic [SERDES_WIDTH-1:0]       last_q, last_d;

  // Sequencer state, including parameters captured at trigger acceptance
  logic [1:0]                    state_q, state_d;
  logic [COARSE_DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [COARSE_WIDTH_WIDTH-1:0] idx_q, idx_d;
  logic [COARSE_WIDTH_WIDTH-1:0] lat_width_q, lat_width_d;
  logic [SERDES_WIDTH-1:0]       lat_first_q, lat_first_d;
  logic [SERDES_WIDTH-1:0]       lat_last_q, lat_last_d;
  logic [SERDES_WIDTH-1:0]       serdes_q, serdes_d;

  // Pattern RAM
  logic [SERDES_WIDTH-1:0]          pattern_ram [0:PATTERN_DEPTH-1];
  logic [SERDES_WIDTH-1:0]          ram_rdata_q;
  logic                             ram_we;
  logic [PATTERN_ADDRESS_WIDTH-1:0] ram_waddr;
  logic [SERDES_WIDTH-1:0]          ram_wdata;
  logic [PATTERN_ADDRESS_WIDTH-1:0] rd_addr;

  logic                          mode_change;
  logic                          emit;
  logic [COARSE_WIDTH_WIDTH-1:0] emit_idx;
  logic [COARSE_WIDTH_WIDTH-1:0] pulse_len;
  logic [SERDES_WIDTH-1:0]       pulse_word;
  logic                          unused_gpio;

  assign unused_gpio   = ^GPIO_OUT;
  assign serdesPattern = serdes_q;

  always_comb begin
    mode_d      = mode_q;
    delay_d     = delay_q;
    first_d     = first_q;
    width_d     = width_q;
    last_d      = last_q;
    mode_change = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = GPIO_OUT[10 +: PATTERN_ADDRESS_WIDTH];
    ram_wdata   = GPIO_OUT[SERDES_WIDTH-1:0];

    if (csrStrobe) begin
      case (GPIO_OUT[31:30])
        OP_SET_MODE: begin
          mode_d      = GPIO_OUT[1:0];
          mode_change = (GPIO_OUT[1:0] != mode_q);
        end
        OP_SET_DELAY: begin
          delay_d = GPIO_OUT[SERDES_WIDTH +: COARSE_DELAY_WIDTH];
          first_d = GPIO_OUT[SERDES_WIDTH-1:0];
        end
        OP_SET_WIDTH: begin
          width_d = GPIO_OUT[SERDES_WIDTH +: COARSE_WIDTH_WIDTH];
          last_d  = GPIO_OUT[SERDES_WIDTH-1:0];
        end
        default: ram_we = 1'b1;
      endcase
    end
  end

  always_comb begin
    pulse_len = (lat_width_q == '0) ? WIDTH_ONE : lat_width_q;
    emit      = 1'b0;
    emit_idx  = idx_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lat_width_d = lat_width_q;
    lat_first_d = lat_first_q;
    lat_last_d  = lat_last_q;
    serdes_d  = '0;

    case (state_q)
      ST_DELAY: begin
        if (cnt_q == '0) begin
          emit     = 1'b1;
          emit_idx = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACTIVE: emit = 1'b1;
      default:   state_d = ST_IDLE;
    endcase

    if (pulse_len == WIDTH_ONE) begin
      pulse_word = lat_first_q & lat_last_q;
    end else if (emit_idx == '0) begin
      pulse_word = lat_first_q;
    end else if (emit_idx == pulse_len - 1'b1) begin
      pulse_word = lat_last_q;
    end else begin
      pulse_word = '1;
    end

    if (emit) begin
      if (mode_q == MODE_PULSE) begin
        if (emit_idx < pulse_len) begin
          serdes_d = pulse_word;
          idx_d    = emit_idx + 1'b1;
          state_d  = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (emit_idx < lat_width_q) begin
        // RAM data was prefetched one cycle earlier from emit_idx
        serdes_d = ram_rdata_q;
        state_d  = ST_ACTIVE;
        if ((mode_q == MODE_LOOP) && (emit_idx + 1'b1 == lat_width_q)) begin
          idx_d = '0;
        end else begin
          idx_d = emit_idx + 1'b1;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (mode_change || (mode_d == MODE_DISABLED)) begin
      state_d  = ST_IDLE;
      serdes_d = '0;
    end

    // Trigger sees this cycle's CSR write already applied
    if (triggerStrobe && (mode_d != MODE_DISABLED)) begin
      state_d     = ST_DELAY;
      cnt_d       = delay_d;
      idx_d       = '0;
      lat_width_d = width_d;
      lat_first_d = first_d;
      lat_last_d  = last_d;
      serdes_d    = '0;
    end
  end

  generate
    if (PATTERN_ADDRESS_WIDTH <= COARSE_WIDTH_WIDTH) begin : g_addr_trunc
      assign rd_addr = idx_d[PATTERN_ADDRESS_WIDTH-1:0];
    end else begin : g_addr_ext
      assign rd_addr = {{(PATTERN_ADDRESS_WIDTH-COARSE_WIDTH_WIDTH){1'b0}}, idx_d};
    end
  endgenerate

  always_ff @(posedge evrClk) begin
    if (ram_we) begin
      pattern_ram[ram_waddr] <= ram_wdata;
    end
    ram_rdata_q <= pattern_ram[rd_addr];
  end

  always_ff @(posedge evrClk) begin
    if (!evrReset_n) begin
      mode_q      <= MODE_DISABLED;
      delay_q     <= '0;
      first_q     <= '0;
      width_q     <= '0;
      last_q      <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lat_width_q <= '0;
      lat_first_q <= '0;
      lat_last_q  <= '0;
      serdes_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      delay_q     <= delay_d;
      first_q     <= first_d;
      width_q     <= width_d;
      last_q      <= last_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lat_width_q <= lat_width_d;
      lat_first_q <= lat_first_d;
      lat_last_q  <= lat_last_d;
      serdes_q    <= serdes_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_evr_output_driver.sv
`default_nettype none
// ============================================================================
// tb_evr_output_driver : directed stimulus with a per-cycle expected-word
// scoreboard checked by an independent monitor. Revision: 1.0
// ============================================================================
module tb_evr_output_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_strobe;
  logic [31:0] gpio_out;
  logic        trig;
  logic [3:0]  serdes;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    int         phase;
  } exp_t;

  exp_t sb[$];
  int   phase = 0;

  evr_output_driver #(
    .SERDES_WIDTH          (4),
    .COARSE_DELAY_WIDTH    (22),
    .COARSE_WIDTH_WIDTH    (22),
    .PATTERN_ADDRESS_WIDTH (12)
  ) dut (
    .evrClk        (clk),
    .evrReset_n    (rst_n),
    .csrStrobe     (csr_strobe),
    .GPIO_OUT      (gpio_out),
    .triggerStrobe (trig),
    .serdesPattern (serdes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the word present after edge N is compared at the negedge with cyc==N
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.cyc < cyc) begin
        miscompares++;
        $display("FAIL missed phase=%0d cyc=%0d (monitor at %0d) required=%h", e.phase, e.cyc, cyc, e.val);
      end else if (serdes !== e.val) begin
        miscompares++;
        $display("FAIL serdes phase=%0d cyc=%0d actual=%h required=%h", e.phase, e.cyc, serdes, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c; e.val = v; e.phase = phase;
    sb.push_back(e);
  endtask

  task automatic push_zeros(input int c0, input int n);
    for (int i = 0; i < n; i++) push(c0 + i, 4'h0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [31:0] w_mode(input logic [1:0] m);
    return {2'b00, 28'd0, m};
  endfunction
  function automatic logic [31:0] w_delay(input logic [21:0] d, input logic [3:0] f);
    return {2'b01, 4'd0, d, f};
  endfunction
  function automatic logic [31:0] w_width(input logic [21:0] w, input logic [3:0] l);
    return {2'b10, 4'd0, w, l};
  endfunction
  function automatic logic [31:0] w_pat(input logic [11:0] a, input logic [3:0] v);
    return {2'b11, 8'd0, a, 6'd0, v};
  endfunction

  task automatic csr(input logic [31:0] w);
    csr_strobe = 1'b1;
    gpio_out   = w;
    tick();
    csr_strobe = 1'b0;
  endtask

  // Returns the cycle index of the trigger edge
  task automatic trigger(output int t);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    t = cyc;
  endtask

  logic [3:0] pat [0:3];

  initial begin
    int t, t2;
    pat[0] = 4'hF; pat[1] = 4'h1; pat[2] = 4'h0; pat[3] = 4'h0;
    rst_n = 1'b0; csr_strobe = 1'b0; gpio_out = '0; trig = 1'b0;

    // Reset with triggers pulsing
    phase = 1;
    for (int i = 0; i < 4; i++) begin
      push(cyc + 1, 4'h0);
      trig = i[0];
      tick();
    end
    trig = 1'b0;
    rst_n = 1'b1;
    trigger(t);
    push_zeros(t, 4);
    wait_until(t + 4);

    // Pulse, delay 0, W=10, first=last=F
    phase = 2;
    csr(w_delay(22'd0, 4'hF));
    csr(w_width(22'd10, 4'hF));
    csr(w_mode(2'd1));
    trigger(t);
    push(t, 4'h0);
    for (int k = 0; k < 10; k++) push(t + 1 + k, 4'hF);
    push_zeros(t + 11, 2);
    wait_until(t + 13);

    // Pulse, delay 5, first=C, last=3
    phase = 3;
    csr(w_delay(22'd5, 4'hC));
    csr(w_width(22'd10, 4'h3));
    trigger(t);
    push_zeros(t, 6);
    push(t + 6, 4'hC);
    for (int k = 1; k < 9; k++) push(t + 6 + k, 4'hF);
    push(t + 15, 4'h3);
    push_zeros(t + 16, 2);
    wait_until(t + 18);

    // Pattern loop with retrigger, then abort by mode change
    phase = 4;
    for (int a = 0; a < 4; a++) csr(w_pat(a[11:0], pat[a]));
    csr(w_delay(22'd2, 4'h0));
    csr(w_width(22'd4, 4'h0));
    csr(w_mode(2'd3));
    trigger(t);
    push_zeros(t, 3);
    for (int k = 0; k < 8; k++) push(t + 3 + k, pat[k % 4]);
    wait_until(t + 10);
    phase = 5;
    trigger(t2);
    push_zeros(t2, 3);
    for (int k = 0; k < 8; k++) push(t2 + 3 + k, pat[k % 4]);
    wait_until(t2 + 10);
    csr(w_mode(2'd2));
    push_zeros(cyc, 3);
    wait_until(cyc + 3);

    // Pattern single, W=4 then W=0
    phase = 6;
    trigger(t);
    push_zeros(t, 3);
    for (int k = 0; k < 4; k++) push(t + 3 + k, pat[k]);
    push_zeros(t + 7, 3);
    wait_until(t + 10);
    phase = 7;
    csr(w_width(22'd0, 4'h0));
    trigger(t);
    push_zeros(t, 9);
    wait_until(t + 9);

    // Abort a pulse by disabling; later trigger ignored
    phase = 8;
    csr(w_delay(22'd1, 4'hA));
    csr(w_width(22'd20, 4'h5));
    csr(w_mode(2'd1));
    trigger(t);
    push_zeros(t, 2);
    push(t + 2, 4'hA);
    for (int k = 3; k < 7; k++) push(t + k, 4'hF);
    wait_until(t + 6);
    csr(w_mode(2'd0));
    push_zeros(t + 7, 3);
    wait_until(t + 10);
    trigger(t);
    push_zeros(t, 6);
    wait_until(t + 6);

    // W=1 pulse: first & last
    phase = 9;
    csr(w_delay(22'd0, 4'hE));
    csr(w_width(22'd1, 4'h7));
    csr(w_mode(2'd1));
    trigger(t);
    push(t + 1, 4'h6);
    push_zeros(t + 2, 2);
    wait_until(t + 4);

    // Same-cycle SET_WIDTH and trigger: new W=3 latched
    phase = 10;
    csr_strobe = 1'b1;
    gpio_out   = w_width(22'd3, 4'h7);
    trigger(t);
    csr_strobe = 1'b0;
    push(t + 1, 4'hE);
    push(t + 2, 4'hF);
    push(t + 3, 4'h7);
    push_zeros(t + 4, 2);
    wait_until(t + 6);

    // Same-cycle SET_MODE enabling and trigger: accepted
    phase = 11;
    csr(w_mode(2'd0));
    csr_strobe = 1'b1;
    gpio_out   = w_mode(2'd1);
    trigger(t);
    csr_strobe = 1'b0;
    push(t, 4'h0);
    push(t + 1, 4'hE);
    push(t + 2, 4'hF);
    push(t + 3, 4'h7);
    push_zeros(t + 4, 2);
    wait_until(t + 6);

    // Drain with a bound
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      miscompares += sb.size();
      $display("FAIL drain %0d expected words never checked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/evr_output_driver.md
Name: evr_output_driver

Overview:
- Event-receiver output generator: on a trigger strobe, emits a delayed pulse or a stored bit pattern as SERDES_WIDTH-bit words, one word per clock, to a downstream output serializer.
- Configured through a single 32-bit opcode-coded CSR write port.
- Sits between the event decoder (trigger source) and the output SERDES primitive.

Parameters:
- SERDES_WIDTH, 4, bits per output word; one word per clock.
- COARSE_DELAY_WIDTH, 22, width of the coarse delay counter (clock ticks).
- COARSE_WIDTH_WIDTH, 22, width of the coarse width/length counter (words).
- PATTERN_ADDRESS_WIDTH, 12, pattern RAM address width (depth 2^N words of SERDES_WIDTH bits).
- Legality: SERDES_WIDTH+COARSE_DELAY_WIDTH <= 30, SERDES_WIDTH+COARSE_WIDTH_WIDTH <= 30, 10+PATTERN_ADDRESS_WIDTH <= 30.

Ports:
- evrClk  input  1  single clock for CSR, trigger and output.
- evrReset_n  input  1  reset.
- csrStrobe  input  1  CSR write strobe, one cycle.
- GPIO_OUT  input  32  CSR write data.
- triggerStrobe  input  1  event trigger, one-cycle pulse.
- serdesPattern  output  SERDES_WIDTH  registered output word; bit 0 earliest in time.

Behaviour:
- Interface: one clock (evrClk); reset is synchronous and active-low (evrReset_n).
- Reset values: mode=DISABLED, delay=0, firstPattern=0, width=0, lastPattern=0, sequencer IDLE, serdesPattern=0. Pattern RAM is not cleared and powers up all-zero.
- CSR write (csrStrobe high at a rising edge) is decoded by GPIO_OUT[31:30]:
  - 00 SET_MODE: mode=[1:0]. Modes: 0 DISABLED, 1 PULSE, 2 PATTERN_SINGLE, 3 PATTERN_LOOP.
  - 01 SET_DELAY: delay=[SERDES_WIDTH +: COARSE_DELAY_WIDTH]; firstPattern=[SERDES_WIDTH-1:0].
  - 10 SET_WIDTH: width W=[SERDES_WIDTH +: COARSE_WIDTH_WIDTH]; lastPattern=[SERDES_WIDTH-1:0].
  - 11 SET_PATTERN: RAM[[10 +: PATTERN_ADDRESS_WIDTH]]=[SERDES_WIDTH-1:0].
  - Unused bits are ignored. Registers update at the strobe edge.
- Parameter latching: delay, W, firstPattern and lastPattern are captured at trigger acceptance. Later writes affect only subsequent triggers.
- Sequencer states: IDLE, DELAY, ACTIVE.
- Trigger acceptance: triggerStrobe high at edge T with mode != DISABLED is accepted in any state (retrigger restarts the sequence from the beginning). It loads the delay counter, and the first output word appears in serdesPattern after edge T+1+delay. delay=0 gives the first word right after edge T+1.
- PULSE mode, W words. Effective W = max(W,1).
  - W=1: one word of firstPattern & lastPattern.
  - W>=2: word0=firstPattern, words 1..W-2 all ones, word W-1=lastPattern.
  - Then zeros, state IDLE.
- PATTERN_SINGLE: outputs RAM[0..W-1] in address order, one word per clock, then zeros and IDLE. W=0 outputs nothing. Addresses wrap modulo 2^PATTERN_ADDRESS_WIDTH. The one-cycle RAM read latency must be hidden: the first word must still meet the T+1+delay timing, so prefetch address 0.
- PATTERN_LOOP: as single, but after word W-1 restarts at address 0 with no gap, indefinitely. W=0 outputs zeros.
- Writing mode=DISABLED: sequencer goes IDLE and serdesPattern=0 from the next edge, mid-operation included. Triggers in DISABLED are ignored.
- Changing mode between non-disabled values mid-sequence aborts to IDLE. Output goes 0 until the next trigger.
- Trigger and CSR write on the same edge: the write is applied first. A SET_MODE in the same cycle decides whether the trigger is accepted; other register writes are latched by that trigger.
- SET_PATTERN to an address currently being played: new data appears when that address is next read.
- Outside DELAY/ACTIVE, serdesPattern is 0.

Test Plan:
- Reset: hold evrReset_n low 4 cycles with triggers pulsing -> serdesPattern=0, mode DISABLED. Post-reset trigger -> output stays 0.
- Pulse: SET_DELAY delay=0, first=F; SET_WIDTH W=10, last=F; mode=1; trigger at edge T -> ten words 0xF after edges T+1..T+10, then 0. Repeat with delay=5, first=0xC, last=0x3 -> C,F×8,3 starting after T+6.
- Pattern loop: write RAM[0..3]=F,1,0,0 (bitstring 0x001F); W=4; mode=3; trigger -> F,1,0,0 repeating continuously. Retrigger mid-loop -> sequence restarts at F after delay.
- Pattern single: same RAM, W=4, mode=2 -> exactly F,1,0,0 once, then 0. W=0 -> no output.
- Abort: mid-pulse write mode=0 -> output 0 from the next edge. A later trigger is ignored.
- Corner: W=1 pulse with first=0xE, last=0x7 -> single word 0x6. A same-cycle SET_WIDTH and trigger -> the new W is used.
